// File: rtl/store_buffer.sv
// store_buffer
//   Circular FIFO of pending stores between the pipeline and data memory.
//   Stores are word-aligned on entry. They drain to memory whenever the
//   memory port is not busy with a load. Loads can forward from the
//   youngest matching buffered store.
//
//   Optional feature, selected by the macro STORE_BUFFER_COALESCE_EN:
//   a store to the same aligned address as the youngest entry overwrites
//   that entry's data instead of allocating a new slot.
//
// Parameters
//   Depth     number of entries (power of 2, >= 2)
//   AdrWidth  byte-address width
//   DataWidth store word width
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-low reset
//   stWrite    store request this cycle
//   stAdr      store byte address
//   stData     store word
//   ldRead     load request this cycle
//   ldAdr      load byte address
//   memBusy    memory port is used by a load this cycle
//   stall      store not accepted; the pipeline must hold
//   fwdHit     load address matches a buffered store
//   fwdData    forwarded store word (0 when fwdHit = 0)
//   memWrite   memory write strobe (head entry drain)
//   memAdr     word-aligned memory write address
//   writeData  memory write word
//   count      number of valid entries
module store_buffer #(
  parameter int Depth     = 4,
  parameter int AdrWidth  = 32,
  parameter int DataWidth = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stWrite,
  input  logic [AdrWidth-1:0]        stAdr,
  input  logic [DataWidth-1:0]       stData,
  input  logic                       ldRead,
  input  logic [AdrWidth-1:0]        ldAdr,
  input  logic                       memBusy,
  output logic                       stall,
  output logic                       fwdHit,
  output logic [DataWidth-1:0]       fwdData,
  output logic                       memWrite,
  output logic [AdrWidth-1:0]        memAdr,
  output logic [DataWidth-1:0]       writeData,
  output logic [$clog2(Depth):0]     count
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [AdrWidth-1:0]  adr_q  [Depth];
  logic [DataWidth-1:0] data_q [Depth];
  logic [Depth-1:0]     valid_q;
  logic [PtrW-1:0]      head_q;
  logic [PtrW-1:0]      tail_q;
  logic [CntW-1:0]      count_q;
  logic [CntW-1:0]      count_d;

  logic [AdrWidth-1:0]  st_aligned;
  logic [AdrWidth-1:0]  ld_aligned;
  logic                 full;
  logic                 drain;
  logic                 coalesce;
  logic                 enq;
  logic [PtrW-1:0]      idx;

  assign st_aligned = {stAdr[AdrWidth-1:2], 2'b00};
  assign ld_aligned = {ldAdr[AdrWidth-1:2], 2'b00};
  assign full       = (count_q == CntW'(Depth));
  // rst gating here keeps every output at 0 while reset is held.
  assign drain      = rst & (count_q != '0) & ~memBusy;

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PtrW-1:0] youngest;
  assign youngest = tail_q - PtrW'(1);
  // The youngest entry is the head only when count is 1; if that head is
  // leaving this cycle it cannot absorb the store.
  assign coalesce = rst & stWrite & (count_q != '0) & valid_q[youngest]
                  & (adr_q[youngest] == st_aligned)
                  & ~(drain & (youngest == head_q));
`else
  assign coalesce = 1'b0;
`endif

  assign enq   = rst & stWrite & ~coalesce & (~full | drain);
  assign stall = rst & stWrite & ~coalesce & full & ~drain;
  assign count = count_q;

  assign memWrite  = drain;
  assign memAdr    = drain ? adr_q[head_q]  : '0;
  assign writeData = drain ? data_q[head_q] : '0;

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    idx     = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      idx = head_q + PtrW'(i);
      if (rst && ldRead && valid_q[idx] && (adr_q[idx] == ld_aligned)) begin
        fwdHit  = 1'b1;
        fwdData = data_q[idx];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({enq, drain})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      // When full and draining, head == tail; this later write re-validates
      // the slot for the incoming store.
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; valid_q qualifies every use.
  always_ff @(posedge clk) begin
    if (enq) begin
      adr_q[tail_q]  <= st_aligned;
      data_q[tail_q] <= stData;
    end
`ifdef STORE_BUFFER_COALESCE_EN
    if (coalesce) begin
      data_q[youngest] <= stData;
    end
`endif
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int Depth = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stWrite;
  logic [AW-1:0] stAdr;
  logic [DW-1:0] stData;
  logic          ldRead;
  logic [AW-1:0] ldAdr;
  logic          memBusy;
  logic          stall;
  logic          fwdHit;
  logic [DW-1:0] fwdData;
  logic          memWrite;
  logic [AW-1:0] memAdr;
  logic [DW-1:0] writeData;
  logic [2:0]    count;

  store_buffer #(.Depth(Depth), .AdrWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst(rst), .stWrite(stWrite), .stAdr(stAdr), .stData(stData),
    .ldRead(ldRead), .ldAdr(ldAdr), .memBusy(memBusy), .stall(stall),
    .fwdHit(fwdHit), .fwdData(fwdData), .memWrite(memWrite), .memAdr(memAdr),
    .writeData(writeData), .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: pending stores, oldest at index 0.
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];

  // Observed outputs from the most recent cycle, for directed checks.
  logic          o_stall, o_hit, o_mw;
  logic [DW-1:0] o_fd, o_wd;
  logic [AW-1:0] o_ma;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, clock, update the model.
  task automatic cyc(input logic r, input logic sw, input logic [AW-1:0] sa,
                     input logic [DW-1:0] sd, input logic lr,
                     input logic [AW-1:0] la, input logic mb);
    int n;
    logic e_drain, e_coal, e_stall, e_hit;
    logic [AW-1:0] e_ma, al, ll;
    logic [DW-1:0] e_wd, e_fd;
    rst = r; stWrite = sw; stAdr = sa; stData = sd;
    ldRead = lr; ldAdr = la; memBusy = mb;
    #4;
    n  = qa.size();
    al = sa & ~32'h3;
    ll = la & ~32'h3;
    e_drain = r && (n > 0) && !mb;
    e_ma = e_drain ? qa[0] : '0;
    e_wd = e_drain ? qd[0] : '0;
    e_coal = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
    e_coal = r && sw && (n > 0) && (qa[n-1] == al) && !(e_drain && n == 1);
`endif
    e_stall = r && sw && !e_coal && (n == Depth) && !e_drain;
    e_hit = 1'b0;
    e_fd  = '0;
    if (r && lr) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (qa[i] == ll) begin
          e_hit = 1'b1;
          e_fd  = qd[i];
          break;
        end
      end
    end
    o_stall = stall; o_hit = fwdHit; o_fd = fwdData;
    o_mw = memWrite; o_ma = memAdr; o_wd = writeData;
    check("stall", 64'(stall), 64'(e_stall));
    check("fwdHit", 64'(fwdHit), 64'(e_hit));
    check("fwdData", 64'(fwdData), 64'(e_fd));
    check("memWrite", 64'(memWrite), 64'(e_drain));
    check("memAdr", 64'(memAdr), 64'(e_ma));
    check("writeData", 64'(writeData), 64'(e_wd));
    if (r) check("count", 64'(count), 64'(n));
    @(posedge clk);
    #1;
    if (!r) begin
      qa.delete();
      qd.delete();
    end else begin
      if (e_drain) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (e_coal) qd[qd.size()-1] = sd;
      else if (sw && !e_stall) begin
        qa.push_back(al);
        qd.push_back(sd);
      end
    end
  endtask

  task automatic idle(input logic mb);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, mb);
  endtask

  task automatic st(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic mb);
    cyc(1'b1, 1'b1, a, d, 1'b0, '0, mb);
  endtask

  initial begin
    // Reset while requests are present: all outputs must stay 0.
    cyc(1'b0, 1'b1, 32'h10, 32'h5, 1'b1, 32'h10, 1'b0);
    cyc(1'b0, 1'b1, 32'h10, 32'h5, 1'b1, 32'h10, 1'b0);
    check("rst_count", 64'(count), 64'd0);

    // Single store, unaligned address, drains next cycle.
    st(32'h1003, 32'hAABBCCDD, 1'b0);
    idle(1'b0);
    check("r36_mw", 64'(o_mw), 64'd1);
    check("r36_adr", 64'(o_ma), 64'h1000);
    check("r36_wd", 64'(o_wd), 64'hAABBCCDD);
    check("r36_cnt", 64'(count), 64'd0);

    // Fill while memory busy, fifth store stalls, then drain in order.
    for (int i = 0; i < 4; i++) st(32'(4 * i), 32'h100 + 32'(i), 1'b1);
    st(32'h10, 32'h999, 1'b1);
    check("r37_stall", 64'(o_stall), 64'd1);
    check("r37_cnt", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check("r37_order", 64'(o_ma), 64'(4 * i));
    end

    // Full buffer, store accepted because a drain frees a slot this cycle.
    for (int i = 0; i < 4; i++) st(32'(4 * i), 32'h200 + 32'(i), 1'b1);
    st(32'h20, 32'h220, 1'b0);
    check("r38_stall", 64'(o_stall), 64'd0);
    check("r38_cnt", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) idle(1'b0);
    check("r38_last", 64'(o_ma), 64'h20);

    // Forwarding picks the youngest matching store.
    st(32'h40, 32'h11, 1'b1);
    st(32'h40, 32'h22, 1'b1);
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 32'h42, 1'b1);
    check("r39_hit", 64'(o_hit), 64'd1);
    check("r39_data", 64'(o_fd), 64'h22);
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 32'h44, 1'b1);
    check("r39_miss", 64'(o_hit), 64'd0);
`ifdef STORE_BUFFER_COALESCE_EN
    check("r40_cnt", 64'(count), 64'd1);
`else
    check("r40_cnt", 64'(count), 64'd2);
`endif
    idle(1'b0);
    idle(1'b0);
    check("r40_empty", 64'(count), 64'd0);

    // Same-cycle store is not forwardable.
    cyc(1'b1, 1'b1, 32'h80, 32'h77, 1'b1, 32'h80, 1'b1);
    check("r28_nohit", 64'(o_hit), 64'd0);
    idle(1'b0);

    // Reset with pending stores: nothing reaches memory afterwards.
    for (int i = 0; i < 3; i++) st(32'h100 + 32'(4 * i), 32'h300 + 32'(i), 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    check("r41_cnt", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("r41_mw", 64'(o_mw), 64'd0);
    end

    // Randomized traffic over a small address pool to provoke matches.
    for (int k = 0; k < 600; k++) begin
      logic r, sw, lr, mb;
      r  = ($urandom_range(0, 60) != 0);
      sw = ($urandom_range(0, 2) != 0);
      lr = $urandom_range(0, 1) == 1;
      mb = ($urandom_range(0, 2) == 0);
      cyc(r, sw, 32'h40 + 32'($urandom_range(0, 15)), $urandom,
          lr, 32'h40 + 32'($urandom_range(0, 15)), mb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
